// File: rtl/jtag_ahb_dr.sv
// JTAG data register that bridges a serial TAP scan chain to a single outstanding
// AHB-style bus request, with status capture and a sticky error flag.
module jtag_ahb_dr #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              TCK,
  input  logic              TRST,
  input  logic              reset,
  input  logic              ahb_select,
  input  logic              dr_capture,
  input  logic              dr_shift,
  input  logic              dr_update,
  input  logic              TDI,
  output logic              TDO,
  output logic              enable,
  output logic              req,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              ack,
  input  logic              ack_err,
  input  logic [DATA_W-1:0] ack_rdata,
  output logic              busy
);

  localparam int DR_W  = ADDR_W + DATA_W + 2;
  localparam int CNT_W = $clog2(DR_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DR_W + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_next;
  logic [DR_W-1:0]   sr;
  logic [CNT_W-1:0]  count;
  logic              sticky;
  logic [DATA_W-1:0] rdata_last;

  logic do_capture, do_shift, do_update;
  logic len_err, go_update, accept, overrun, ack_done, set_sticky;

  assign TDO    = ahb_select ? sr[0] : 1'b0;
  assign enable = ahb_select & dr_update;

  // Strobe decode with capture > shift > update priority; all strobes need ahb_select.
  always_comb begin
    do_capture = ahb_select & dr_capture;
    do_shift   = ahb_select & ~dr_capture & dr_shift;
    do_update  = ahb_select & ~dr_capture & ~dr_shift & dr_update;
    len_err    = do_update & (count != CNT_FULL);
    go_update  = do_update & (count == CNT_FULL) & sr[0];
    accept     = go_update & (state == IDLE);
    overrun    = go_update & (state == BUSY);
    ack_done   = (state == BUSY) & ack;
    set_sticky = len_err | overrun | (ack_done & ack_err);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (ack)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST)      state <= IDLE;
    else if (reset) state <= IDLE;
    else            state <= state_next;
  end

  // A set event in the capture cycle wins over the capture's clear of sticky.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      sr         <= '0;
      count      <= '0;
      sticky     <= 1'b0;
      rdata_last <= '0;
      req        <= 1'b0;
      busy       <= 1'b0;
      req_write  <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
    end else if (reset) begin
      sr         <= '0;
      count      <= '0;
      sticky     <= 1'b0;
      rdata_last <= '0;
      req        <= 1'b0;
      busy       <= 1'b0;
      req_write  <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
    end else begin
      if (do_capture) begin
        sr    <= {rdata_last, req_addr, sticky, busy};
        count <= '0;
      end else if (do_shift) begin
        sr <= {TDI, sr[DR_W-1:1]};
        if (count != CNT_MAX) count <= count + 1'b1;
      end
      if (accept) begin
        req_write <= sr[1];
        req_addr  <= sr[ADDR_W+1:2];
        req_wdata <= sr[DR_W-1:ADDR_W+2];
      end
      if (ack_done && !req_write) rdata_last <= ack_rdata;
      sticky <= (sticky & ~do_capture) | set_sticky;
      req    <= (state_next == BUSY);
      busy   <= (state_next == BUSY);
    end
  end

endmodule

// File: tb/tb_jtag_ahb_dr.sv
// Self-checking bench for jtag_ahb_dr (ADDR_W=8, DATA_W=8): directed scenarios plus
// randomized transactions compared every cycle against a queue-based reference model.
module tb_jtag_ahb_dr;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DRW = AW + DW + 2;

  logic          TCK = 1'b0;
  logic          TRST = 1'b0;
  logic          reset = 1'b0;
  logic          ahb_select = 1'b1;
  logic          dr_capture = 1'b0, dr_shift = 1'b0, dr_update = 1'b0;
  logic          TDI = 1'b0;
  logic          TDO, enable, req, req_write, busy;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          ack = 1'b0, ack_err = 1'b0;
  logic [DW-1:0] ack_rdata = '0;

  int checks = 0;
  int passes = 0;

  jtag_ahb_dr #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .TCK(TCK), .TRST(TRST), .reset(reset), .ahb_select(ahb_select),
    .dr_capture(dr_capture), .dr_shift(dr_shift), .dr_update(dr_update),
    .TDI(TDI), .TDO(TDO), .enable(enable), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .ack_err(ack_err),
    .ack_rdata(ack_rdata), .busy(busy)
  );

  always #5 TCK = ~TCK;

  // Reference model: the DR is a bit queue (index 0 = bit 0, next out on TDO).
  bit            mq[$];
  int            m_count;
  bit            m_busy, m_sticky, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  task automatic modelReset();
    mq.delete();
    for (int i = 0; i < DRW; i++) mq.push_back(1'b0);
    m_count = 0; m_busy = 0; m_sticky = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  task automatic modelStep();
    logic [DRW-1:0] word;
    bit set_ev, clr, n_busy;
    logic [DW-1:0] n_rdata;
    if (!TRST || reset) begin
      modelReset();
    end else begin
      set_ev = 0; clr = 0; n_busy = m_busy; n_rdata = m_rdata;
      if (m_busy && ack) begin
        n_busy = 0;
        if (!m_we) n_rdata = ack_rdata;
        if (ack_err) set_ev = 1;
      end
      if (ahb_select) begin
        if (dr_capture) begin
          word = {m_rdata, m_addr, m_sticky, m_busy};
          mq.delete();
          for (int i = 0; i < DRW; i++) mq.push_back(word[i]);
          m_count = 0;
          clr = 1;
        end else if (dr_shift) begin
          void'(mq.pop_front());
          mq.push_back(TDI);
          m_count = (m_count < DRW + 1) ? m_count + 1 : DRW + 1;
        end else if (dr_update) begin
          if (m_count != DRW) set_ev = 1;
          else if (mq[0]) begin
            if (m_busy) set_ev = 1;
            else begin
              n_busy = 1;
              m_we = mq[1];
              for (int i = 0; i < AW; i++) m_addr[i] = mq[2 + i];
              for (int i = 0; i < DW; i++) m_wdata[i] = mq[2 + AW + i];
            end
          end
        end
      end
      m_sticky = (clr ? 1'b0 : m_sticky) | set_ev;
      m_busy = n_busy;
      m_rdata = n_rdata;
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) passes++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic checkOutput();
    checkVal("req", 32'(req), 32'(m_busy));
    checkVal("busy", 32'(busy), 32'(m_busy));
    checkVal("req_write", 32'(req_write), 32'(m_we));
    checkVal("req_addr", 32'(req_addr), 32'(m_addr));
    checkVal("req_wdata", 32'(req_wdata), 32'(m_wdata));
    checkVal("TDO", 32'(TDO), 32'(ahb_select ? mq[0] : 1'b0));
    checkVal("enable", 32'(enable), 32'(ahb_select & dr_update));
  endtask

  task automatic tick();
    modelStep();
    @(posedge TCK);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic cap, input logic sh, input logic upd, input logic tdi);
    dr_capture = cap; dr_shift = sh; dr_update = upd; TDI = tdi;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Capture, shift nbits of the command word, then update (optionally with ack in that cycle).
  task automatic sendCmd(input logic go, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int nbits, input logic with_ack,
                         input logic err);
    logic [DRW-1:0] w;
    w = {d, a, we, go};
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) applyStimulus(1'b0, 1'b1, 1'b0, w[i % DRW]);
    ack = with_ack; ack_err = err; ack_rdata = DW'($urandom);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    ack = 1'b0; ack_err = 1'b0;
  endtask

  task automatic doAck(input logic err, input logic [DW-1:0] rd);
    ack = 1'b1; ack_err = err; ack_rdata = rd;
    idle(1);
    ack = 1'b0; ack_err = 1'b0;
  endtask

  task automatic readDr(output logic [DRW-1:0] w);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    w[0] = TDO;
    for (int i = 1; i < DRW; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'($urandom));
      w[i] = TDO;
    end
  endtask

  logic [DRW-1:0] rb;

  initial begin
    modelReset();
    idle(2);
    checkVal("reset_req", 32'(req), 32'd0);
    checkVal("reset_tdo", 32'(TDO), 32'd0);
    TRST = 1'b1;
    idle(1);

    // Directed write
    sendCmd(1'b1, 1'b1, 8'h3C, 8'hA5, DRW, 1'b0, 1'b0);
    checkVal("wr_req", 32'(req), 32'd1);
    checkVal("wr_we", 32'(req_write), 32'd1);
    checkVal("wr_addr", 32'(req_addr), 32'h3C);
    checkVal("wr_wdata", 32'(req_wdata), 32'hA5);
    idle(2);
    checkVal("wr_hold_addr", 32'(req_addr), 32'h3C);
    doAck(1'b0, 8'h77);
    checkVal("wr_done_req", 32'(req), 32'd0);

    // Directed read and readback of captured status
    sendCmd(1'b1, 1'b0, 8'h10, 8'h00, DRW, 1'b0, 1'b0);
    idle(1);
    doAck(1'b0, 8'h5A);
    readDr(rb);
    checkVal("rd_capture", 32'(rb), 32'({8'h5A, 8'h10, 1'b0, 1'b0}));
    idle(1);

    // Length error sets sticky, read once then cleared
    sendCmd(1'b1, 1'b1, 8'h22, 8'h33, DRW - 1, 1'b0, 1'b0);
    checkVal("len_no_req", 32'(req), 32'd0);
    readDr(rb);
    checkVal("len_sticky1", 32'(rb[1]), 32'd1);
    readDr(rb);
    checkVal("len_sticky2", 32'(rb[1]), 32'd0);

    // Overrun while busy, then ack with error
    sendCmd(1'b1, 1'b1, 8'h44, 8'h55, DRW, 1'b0, 1'b0);
    sendCmd(1'b1, 1'b1, 8'h66, 8'h77, DRW, 1'b0, 1'b0);
    checkVal("ovr_addr", 32'(req_addr), 32'h44);
    doAck(1'b1, 8'h00);
    idle(2);
    checkVal("ovr_one_txn", 32'(req), 32'd0);
    readDr(rb);
    checkVal("ovr_sticky", 32'(rb[1]), 32'd1);

    // Update in the same cycle as ack: completes current, drops update
    sendCmd(1'b1, 1'b0, 8'h01, 8'h02, DRW, 1'b0, 1'b0);
    sendCmd(1'b1, 1'b1, 8'h99, 8'h88, DRW, 1'b1, 1'b0);
    checkVal("ackupd_req", 32'(req), 32'd0);
    readDr(rb);
    checkVal("ackupd_sticky", 32'(rb[1]), 32'd1);

    // Async TRST mid-transaction
    sendCmd(1'b1, 1'b1, 8'hC3, 8'h3C, DRW, 1'b0, 1'b0);
    #2 TRST = 1'b0;
    #1 modelReset();
    checkOutput();
    checkVal("trst_req", 32'(req), 32'd0);
    idle(1);
    TRST = 1'b1;
    doAck(1'b1, 8'hFF);
    idle(1);
    checkVal("trst_ack_ignored", 32'({req, busy, req_write, req_addr, req_wdata}), 32'd0);

    // Synchronous soft reset mid-transaction
    sendCmd(1'b1, 1'b0, 8'h5E, 8'h00, DRW, 1'b0, 1'b0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    doAck(1'b0, 8'hAB);
    checkVal("soft_rst_req", 32'(req), 32'd0);

    // Deselected: strobes toggle, nothing changes
    sendCmd(1'b1, 1'b1, 8'h12, 8'h34, DRW - 2, 1'b0, 1'b0);
    ahb_select = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      checkVal("desel_tdo", 32'(TDO), 32'd0);
    end
    ahb_select = 1'b1;
    idle(1);
    for (int i = 0; i < DRW; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'($urandom));

    // Randomized transactions
    for (int it = 0; it < 30; it++) begin
      int r, nb;
      r = int'($urandom_range(0, 9));
      nb = (r == 0) ? DRW - 1 : (r == 1) ? DRW + 1 : DRW;
      sendCmd(1'($urandom_range(0, 7) != 0), 1'($urandom), AW'($urandom), DW'($urandom),
              nb, 1'b0, 1'b0);
      idle(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0)
        sendCmd(1'b1, 1'($urandom), AW'($urandom), DW'($urandom), DRW,
                1'($urandom), 1'($urandom));
      if (m_busy) doAck(1'($urandom_range(0, 3) == 0), DW'($urandom));
      else if ($urandom_range(0, 1) == 0) doAck(1'b1, DW'($urandom));
      if ($urandom_range(0, 2) == 0) readDr(rb);
      idle(1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
